load_store_unit: RTL

Byte-addressed load/store front end for the core_lapido MEM stage, placed directly upstream of the word-wide `data_mem` RAM. It accepts one request at a time from the pipeline over a valid/ready handshake. It converts byte addresses to word indices and performs byte and halfword stores as read-modify-write, because the RAM has only a full-word write enable. It sign- or zero-extends loads and reports misaligned or out-of-range accesses instead of touching memory.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit_lane_align.sv | 42 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the core_lapido MEM-stage load/store unit.
// Holds the access-size codes, the FSM state type and the request legality check.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_MERGE_WR = 2'b10,
        ST_RESP     = 2'b11
    } lsu_state_e;

    // Reserved size and any lane that straddles its natural alignment are illegal.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and word-RAM port bundle of the load/store unit.
// The slave modport is the unit's view; master is the pipeline plus RAM side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_write_en
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_write_en
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane steering: extracts and extends a load lane, and splices
// right-aligned store data into a RAM word for read-modify-write.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [15:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rd_word_i[{off_i, 3'b000} +: 8];
    assign half_s = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    // Load lane select with sign or zero extension.
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (size_i)
            SIZE_BYTE: ld_data_o = unsigned_i ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SIZE_HALF: ld_data_o = unsigned_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SIZE_WORD: ld_data_o = rd_word_i;
            default:   ld_data_o = 32'h0000_0000;
        endcase
    end

    // Store merge: the untouched lanes keep the current RAM contents.
    always_comb begin
        merged_o = rd_word_i;
        case (size_i)
            SIZE_BYTE: merged_o[{off_i, 3'b000} +: 8]       = st_data_i[7:0];
            SIZE_HALF: merged_o[{off_i[1], 4'b0000} +: 16]  = st_data_i;
            default:   merged_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide RAM with a single write enable.
// One request in flight; sub-word stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
)(
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        req_bad_s;
    logic [31:0] ld_data_s;
    logic [31:0] merged_s;

    lsu_lane_align u_align (
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rd_word_i  (bus.mem_read_data),
        .st_data_i  (wdata_q[15:0]),
        .ld_data_o  (ld_data_s),
        .merged_o   (merged_s)
    );

    assign req_bad_s = size_misaligned(bus.req_size, bus.req_addr[1:0]) ||
                       ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_L);

    // Next-state, request latch and response register updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    size_d  = bus.req_size;
                    off_d   = bus.req_addr[1:0];
                    addr_d  = {2'b00, bus.req_addr[31:2]};
                    wdata_d = bus.req_wdata;
                    if (req_bad_s) begin
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = ld_data_s;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (size_q == SIZE_WORD) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    wdata_d = merged_s;
                    state_d = ST_MERGE_WR;
                end
            end
            ST_MERGE_WR: begin
                rdata_d = 32'h0000_0000;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RESP);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            off_q   <= 2'b00;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Decoded straight from the state register so reset kills a pending write at once.
    assign bus.mem_write_en   = (state_q == ST_MERGE_WR) ||
                                ((state_q == ST_ACCESS) && we_q && (size_q == SIZE_WORD));
    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.req_ready      = ready_q;
    assign bus.resp_valid     = valid_q;
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;

endmodule
